vga_line_buffer: RTL and testbench

- Ping-pong line buffer that sits directly upstream of the VGA output driver and feeds its r/g/b inputs.
- Accepts camera-side RGB pixels, already colour-converted and in the VGA clock domain, as valid-strobed lines.
- Returns them one pixel per read strobe during the VGA active region.
- Decouples the camera line cadence from VGA line timing by buffering up to two complete lines.

---
 rtl/vga_line_buffer_if.sv | 26 ++
 rtl/vga_line_buffer.sv | 179 +++++++++++++++++
 tb/tb_vga_line_buffer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_buffer_if.sv
// Pixel-side bundle between the camera line source, the line buffer, and the VGA driver.
// The master drives pixels, read strobes and clr_err; the slave returns rgb and status.
interface vga_line_buffer_if;
  logic        in_valid;
  logic        in_sol;
  logic [23:0] in_rgb;
  logic        rd_line_start;
  logic        rd_en;
  logic        clr_err;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic [1:0]  lines_buffered;
  logic        overflow;
  logic        underflow;

  modport master (
    output in_valid, in_sol, in_rgb, rd_line_start, rd_en, clr_err,
    input  r, g, b, lines_buffered, overflow, underflow
  );

  modport slave (
    input  in_valid, in_sol, in_rgb, rd_line_start, rd_en, clr_err,
    output r, g, b, lines_buffered, overflow, underflow
  );
endinterface

// File: rtl/vga_line_buffer.sv
// Two-bank ping-pong line buffer between the camera pixel stream and the VGA driver.
// A bank's full flag hands ownership from the writer to the reader and back.
//
// state    | meaning
// W_IDLE   | waiting for in_sol to start a line in wr_bank
// W_FILL   | storing pixels of the current line into wr_bank
// W_DROP   | discarding an incoming line because no bank was free
// R_IDLE   | waiting for rd_line_start
// R_ACTIVE | streaming rd_bank out, one pixel per rd_en
// R_BLANK  | line started with nothing buffered; rd_en yields black
module vga_line_buffer #(
  parameter int LINE_W = 640,
  parameter int ADDR_W = 10
) (
  input logic         clk,
  input logic         reset_n,
  vga_line_buffer_if.slave bus
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_BLANK} r_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_W - 1);

  logic [23:0] mem_q [0:1][0:LINE_W-1];

  w_state_t    w_state_q, w_state_d;
  r_state_t    r_state_q, r_state_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]  full_q, full_d;
  logic [23:0] rgb_q, rgb_d;
  logic [1:0]  lines_buffered_q, lines_buffered_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [1:0]        full_set, full_clr;
  logic              ovf_set, unf_set;
  logic              start_eval, chk_bank;
  logic              sol;

  assign sol = bus.in_valid & bus.in_sol;

  // Write side
  always_comb begin
    w_state_d = w_state_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    mem_we    = 1'b0;
    mem_wa    = '0;
    full_set  = 2'b00;
    ovf_set   = 1'b0;
    case (w_state_q)
      W_FILL: begin
        if (sol) begin
          mem_we    = 1'b1;
          wr_addr_d = ADDR_W'(1);
        end else if (bus.in_valid) begin
          mem_we = 1'b1;
          mem_wa = wr_addr_q;
          if (wr_addr_q == LAST_ADDR) begin
            full_set[wr_bank_q] = 1'b1;
            wr_bank_d = ~wr_bank_q;
            w_state_d = W_IDLE;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        if (sol) begin
          if (!full_q[wr_bank_q]) begin
            mem_we    = 1'b1;
            wr_addr_d = ADDR_W'(1);
            w_state_d = W_FILL;
          end else begin
            ovf_set   = 1'b1;
            w_state_d = W_DROP;
          end
        end
      end
    endcase
  end

  // Read side; an abandoned line frees its bank and the start is judged on the other bank
  always_comb begin
    r_state_d  = r_state_q;
    rd_bank_d  = rd_bank_q;
    rd_addr_d  = rd_addr_q;
    rgb_d      = '0;
    full_clr   = 2'b00;
    unf_set    = 1'b0;
    start_eval = 1'b0;
    chk_bank   = rd_bank_q;
    case (r_state_q)
      R_ACTIVE: begin
        if (bus.rd_line_start) begin
          full_clr[rd_bank_q] = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          chk_bank   = ~rd_bank_q;
          start_eval = 1'b1;
        end else if (bus.rd_en) begin
          rgb_d = mem_q[rd_bank_q][rd_addr_q];
          if (rd_addr_q == LAST_ADDR) begin
            full_clr[rd_bank_q] = 1'b1;
            rd_bank_d = ~rd_bank_q;
            r_state_d = R_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        if (bus.rd_line_start) start_eval = 1'b1;
      end
    endcase
    if (start_eval) begin
      if (full_q[chk_bank]) begin
        rd_addr_d = '0;
        r_state_d = R_ACTIVE;
      end else begin
        unf_set   = 1'b1;
        r_state_d = R_BLANK;
      end
    end
  end

  always_comb begin
    full_d           = (full_q | full_set) & ~full_clr;
    lines_buffered_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
    overflow_d       = ovf_set | (overflow_q & ~bus.clr_err);
    underflow_d      = unf_set | (underflow_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q        <= W_IDLE;
      r_state_q        <= R_IDLE;
      wr_bank_q        <= 1'b0;
      rd_bank_q        <= 1'b0;
      wr_addr_q        <= '0;
      rd_addr_q        <= '0;
      full_q           <= 2'b00;
      rgb_q            <= '0;
      lines_buffered_q <= 2'd0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
    end else begin
      w_state_q        <= w_state_d;
      r_state_q        <= r_state_d;
      wr_bank_q        <= wr_bank_d;
      rd_bank_q        <= rd_bank_d;
      wr_addr_q        <= wr_addr_d;
      rd_addr_q        <= rd_addr_d;
      full_q           <= full_d;
      rgb_q            <= rgb_d;
      lines_buffered_q <= lines_buffered_d;
      overflow_q       <= overflow_d;
      underflow_q      <= underflow_d;
    end
  end

  // Storage array carries no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_bank_q][mem_wa] <= bus.in_rgb;
  end

  assign bus.r              = rgb_q[23:16];
  assign bus.g              = rgb_q[15:8];
  assign bus.b              = rgb_q[7:0];
  assign bus.lines_buffered = lines_buffered_q;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Bench for vga_line_buffer with LINE_W=4: a vector table, directed corner sequences,
// and random traffic, all compared against a FIFO-of-lines reference model.
module tb_vga_line_buffer;

  localparam int LW = 4;
  typedef logic [23:0] px_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   failed;

  vga_line_buffer_if bus();

  vga_line_buffer #(.LINE_W(LW), .ADDR_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: complete lines waiting in a FIFO, a line being shown, a line being assembled
  px_t  pend[$];
  px_t  part[$];
  px_t  cur[LW];
  bit   filling;
  bit   active;
  int   ridx;
  bit   m_ovf;
  bit   m_unf;
  px_t  m_rgb;

  function automatic int m_lines();
    return pend.size() / LW + (active ? 1 : 0);
  endfunction

  task automatic model_reset();
    pend.delete();
    part.delete();
    filling = 0;
    active  = 0;
    ridx    = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_rgb   = '0;
  endtask

  task automatic model_cycle(input bit v, input bit sol, input px_t px,
                             input bit st, input bit re, input bit clr);
    int  occ_pre;
    bit  ovf_set;
    bit  unf_set;
    occ_pre = m_lines();
    ovf_set = 0;
    unf_set = 0;
    m_rgb   = '0;
    if (st) begin
      active = 0;
      if (pend.size() >= LW) begin
        for (int i = 0; i < LW; i++) cur[i] = pend.pop_front();
        active = 1;
        ridx   = 0;
      end else begin
        unf_set = 1;
      end
    end else if (re && active) begin
      m_rgb = cur[ridx];
      ridx++;
      if (ridx == LW) active = 0;
    end
    if (v) begin
      if (sol) begin
        if (filling || occ_pre < 2) begin
          part.delete();
          part.push_back(px);
          filling = 1;
        end else begin
          ovf_set = 1;
        end
      end else if (filling) begin
        part.push_back(px);
        if (part.size() == LW) begin
          foreach (part[i]) pend.push_back(part[i]);
          part.delete();
          filling = 0;
        end
      end
    end
    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = unf_set ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit v, input bit sol, input px_t px,
                      input bit st, input bit re, input bit clr);
    bus.in_valid      = v;
    bus.in_sol        = sol;
    bus.in_rgb        = px;
    bus.rd_line_start = st;
    bus.rd_en         = re;
    bus.clr_err       = clr;
    model_cycle(v, sol, px, st, re, clr);
    @(posedge clk);
    #1;
    check("rgb", {8'h0, bus.r, bus.g, bus.b}, {8'h0, m_rgb});
    check("lines_buffered", {30'h0, bus.lines_buffered}, m_lines());
    check("overflow", {31'h0, bus.overflow}, {31'h0, m_ovf});
    check("underflow", {31'h0, bus.underflow}, {31'h0, m_unf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic send_line(input px_t p0, input px_t p1, input px_t p2, input px_t p3);
    step(1, 1, p0, 0, 0, 0);
    step(1, 0, p1, 0, 0, 0);
    step(1, 0, p2, 0, 0, 0);
    step(1, 0, p3, 0, 0, 0);
  endtask

  task automatic read_line();
    step(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < LW; i++) step(0, 0, '0, 0, 1, 0);
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    bus.in_valid      = 0;
    bus.in_sol        = 0;
    bus.in_rgb        = '0;
    bus.rd_line_start = 0;
    bus.rd_en         = 0;
    bus.clr_err       = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit   v, sol;
    px_t  px;
    bit   st, re, clr;
    px_t  exp_rgb;
    logic [1:0] exp_lb;
    bit   exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    tests  = 0;
    failed = 0;

    vecs[0]  = '{1, 1, 24'h111111, 0, 0, 0, 24'h0,      2'd0, 0, 0};
    vecs[1]  = '{1, 0, 24'h222222, 0, 0, 0, 24'h0,      2'd0, 0, 0};
    vecs[2]  = '{1, 0, 24'h333333, 0, 0, 0, 24'h0,      2'd0, 0, 0};
    vecs[3]  = '{1, 0, 24'h444444, 0, 0, 0, 24'h0,      2'd1, 0, 0};
    vecs[4]  = '{0, 0, 24'h0,      1, 0, 0, 24'h0,      2'd1, 0, 0};
    vecs[5]  = '{0, 0, 24'h0,      0, 1, 0, 24'h111111, 2'd1, 0, 0};
    vecs[6]  = '{0, 0, 24'h0,      0, 1, 0, 24'h222222, 2'd1, 0, 0};
    vecs[7]  = '{0, 0, 24'h0,      0, 1, 0, 24'h333333, 2'd1, 0, 0};
    vecs[8]  = '{0, 0, 24'h0,      0, 1, 0, 24'h444444, 2'd0, 0, 0};
    vecs[9]  = '{0, 0, 24'h0,      0, 0, 0, 24'h0,      2'd0, 0, 0};
    vecs[10] = '{1, 0, 24'h555555, 0, 1, 0, 24'h0,      2'd0, 0, 0};

    do_reset();
    check("reset_rgb", {8'h0, bus.r, bus.g, bus.b}, 32'h0);
    check("reset_lines", {30'h0, bus.lines_buffered}, 32'h0);
    check("reset_flags", {30'h0, bus.overflow, bus.underflow}, 32'h0);

    // Basic write-then-read line
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].sol, vecs[i].px, vecs[i].st, vecs[i].re, vecs[i].clr);
      check("vec_rgb", {8'h0, bus.r, bus.g, bus.b}, {8'h0, vecs[i].exp_rgb});
      check("vec_lines", {30'h0, bus.lines_buffered}, {30'h0, vecs[i].exp_lb});
      check("vec_flags", {30'h0, bus.overflow, bus.underflow},
            {30'h0, vecs[i].exp_ovf, vecs[i].exp_unf});
    end

    // Three lines with no reads: third is dropped
    send_line(24'h010101, 24'h010102, 24'h010103, 24'h010104);
    send_line(24'h020201, 24'h020202, 24'h020203, 24'h020204);
    send_line(24'h030301, 24'h030302, 24'h030303, 24'h030304);
    check("ovf_lines", {30'h0, bus.lines_buffered}, 32'd2);
    check("ovf_flag", {31'h0, bus.overflow}, 32'd1);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, 1, 0);
    check("ovf_first_px", {8'h0, bus.r, bus.g, bus.b}, 32'h010101);
    for (int i = 1; i < LW; i++) step(0, 0, '0, 0, 1, 0);
    read_line();
    check("ovf_last_px", {8'h0, bus.r, bus.g, bus.b}, 32'h020204);
    step(0, 0, '0, 0, 0, 1);
    check("ovf_cleared", {31'h0, bus.overflow}, 32'd0);

    // Underflow on empty buffer, then a real line
    step(0, 0, '0, 1, 0, 0);
    check("unf_flag", {31'h0, bus.underflow}, 32'd1);
    for (int i = 0; i < LW; i++) step(0, 0, '0, 0, 1, 0);
    send_line(24'h0C0C01, 24'h0C0C02, 24'h0C0C03, 24'h0C0C04);
    read_line();
    step(0, 0, '0, 0, 0, 1);

    // Restart mid-line: only the second start's pixels survive
    step(1, 1, 24'h0000F0, 0, 0, 0);
    step(1, 0, 24'h0000F1, 0, 0, 0);
    send_line(24'h0000A0, 24'h0000A1, 24'h0000A2, 24'h0000A3);
    check("restart_flags", {30'h0, bus.overflow, bus.underflow}, 32'd0);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, 1, 0);
    check("restart_px0", {8'h0, bus.r, bus.g, bus.b}, 32'h0000A0);
    for (int i = 1; i < LW; i++) step(0, 0, '0, 0, 1, 0);
    check("restart_px3", {8'h0, bus.r, bus.g, bus.b}, 32'h0000A3);

    // Line completes on the same cycle as rd_line_start, then start one cycle later
    step(1, 1, 24'h0D0D01, 0, 0, 0);
    step(1, 0, 24'h0D0D02, 0, 0, 0);
    step(1, 0, 24'h0D0D03, 0, 0, 0);
    step(1, 0, 24'h0D0D04, 1, 0, 0);
    check("same_cycle_unf", {31'h0, bus.underflow}, 32'd1);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, 1, 0);
    check("next_cycle_px", {8'h0, bus.r, bus.g, bus.b}, 32'h0D0D01);
    for (int i = 1; i < LW; i++) step(0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, 0, 1);

    // Reset in the middle of a read and a write
    send_line(24'h0E0E01, 24'h0E0E02, 24'h0E0E03, 24'h0E0E04);
    step(0, 0, '0, 1, 0, 0);
    step(1, 1, 24'h0F0F01, 0, 1, 0);
    step(1, 0, 24'h0F0F02, 0, 1, 0);
    check("pre_reset_px", {8'h0, bus.r, bus.g, bus.b}, 32'h0E0E02);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rgb", {8'h0, bus.r, bus.g, bus.b}, 32'h0);
    check("async_lines", {30'h0, bus.lines_buffered}, 32'h0);
    do_reset();
    check("post_reset_flags", {30'h0, bus.overflow, bus.underflow}, 32'd0);
    send_line(24'h101010, 24'h202020, 24'h303030, 24'h404040);
    check("post_reset_lines", {30'h0, bus.lines_buffered}, 32'd1);
    read_line();
    check("post_reset_last", {8'h0, bus.r, bus.g, bus.b}, 32'h404040);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, px_t'($urandom),
           $urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 40) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
